bpm_display_scan: RTL and testbench

BPM_DISPLAY_SCAN -- requirements
Module: bpm_display_scan

---
 rtl/display_pkg.sv | 28 ++
 rtl/bcd_to_seg.sv | 14 +
 rtl/bpm_display_scan.sv | 119 +++++++++++
 tb/tb_bpm_display_scan.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the BPM 3-digit multiplexed 7-segment display.
// Segment values are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_e;

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_digits_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Index 0 sits in the low bits, so the list reads 9 down to 0.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
    end

endmodule

// File: rtl/bpm_display_scan.sv
// Time-multiplexed scan of a 3-digit BPM readout with leading-zero blanking
// and a whole-display alarm flash. Outputs only change on slot boundaries.
module bpm_display_scan
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned FLASH_FRAMES = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_lz,
    input  logic       alarm,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic [CW-1:0] count_q, count_d;
    logic [FW-1:0] frame_q, frame_d;
    scan_state_e   state_q, state_d;
    bcd_digits_t   shadow_q, shadow_d;
    logic          flash_on_q, flash_on_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick;
    logic [3:0]    digit_sel;
    logic [6:0]    digit_seg;
    logic [3:0]    an_pat;
    logic          blank;

    assign tick = (count_q == CW'(SCAN_DIV - 1));

    always_comb begin
        count_d  = tick ? '0 : count_q + CW'(1);
        state_d  = tick ? scan_state_e'(state_q + 2'd1) : state_q;
        shadow_d = load ? '{hundreds: hundreds, tens: tens, ones: ones} : shadow_q;
    end

    // Flash phase advances only at frame boundaries (leaving the dead slot).
    always_comb begin
        frame_d    = frame_q;
        flash_on_d = flash_on_q;
        if (!alarm) begin
            frame_d    = '0;
            flash_on_d = 1'b1;
        end else if (tick && state_q == DIG3) begin
            if (frame_q == FW'(FLASH_FRAMES - 1)) begin
                frame_d    = '0;
                flash_on_d = !flash_on_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    always_comb begin
        digit_sel = 4'd0;
        an_pat    = AN_OFF;
        case (state_d)
            DIG0: begin digit_sel = shadow_q.ones;     an_pat = 4'b1110; end
            DIG1: begin digit_sel = shadow_q.tens;     an_pat = 4'b1101; end
            DIG2: begin digit_sel = shadow_q.hundreds; an_pat = 4'b1011; end
            default: begin digit_sel = 4'd0;           an_pat = AN_OFF;  end
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (digit_sel),
        .seg (digit_seg)
    );

    // Shadow_q (not shadow_d) feeds the decode, so a load on the tick edge
    // only shows up from the following slot.
    always_comb begin
        blank = (state_d == DIG3) || !flash_on_d
             || (blank_lz && state_d == DIG2 && shadow_q.hundreds == 4'd0)
             || (blank_lz && state_d == DIG1 && shadow_q.hundreds == 4'd0
                          && shadow_q.tens == 4'd0);
        an_d  = an_q;
        seg_d = seg_q;
        if (tick) begin
            an_d  = blank ? AN_OFF : an_pat;
            seg_d = blank ? SEG_BLANK : digit_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            frame_q    <= '0;
            state_q    <= DIG0;
            shadow_q   <= '0;
            flash_on_q <= 1'b1;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
        end else begin
            count_q    <= count_d;
            frame_q    <= frame_d;
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            flash_on_q <= flash_on_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_bpm_display_scan.sv
// Bench for bpm_display_scan: directed scenarios plus random traffic, checked
// every cycle against a timeline model of the scan (slot = elapsed cycles / SCAN_DIV).
module tb_bpm_display_scan;

    localparam int SD = 4;
    localparam int FF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] hundreds = 4'd0, tens = 4'd0, ones = 4'd0;
    logic       blank_lz = 1'b0;
    logic       alarm = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    bpm_display_scan #(.SCAN_DIV(SD), .FLASH_FRAMES(FF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .blank_lz (blank_lz),
        .alarm    (alarm),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: cycles since reset release, completed frames under alarm, shadow digits.
    int         ncyc = 0;
    int         frames = 0;
    logic [3:0] sh_h = 4'd0, sh_t = 4'd0, sh_o = 4'd0;
    logic [3:0] exp_an = 4'hF;
    logic [6:0] exp_seg = 7'h7F;
    string      tag = "reset";

    logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        return (d > 4'd9) ? 7'h3F : seg_ref[d];
    endfunction

    task automatic check();
        checks++;
        assert (an === exp_an && seg === exp_seg && dp === 1'b1)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d an=%b exp=%b seg=%h exp=%h dp=%b", tag, ncyc,
                   an, exp_an, seg, exp_seg, dp);
        end
    endtask

    task automatic step();
        logic [3:0] oh, ot, oo, d, onehot;
        int         slot, prev;
        logic       on, blank, tick;
        @(posedge clk);
        oh = sh_h; ot = sh_t; oo = sh_o;
        if (load) begin sh_h = hundreds; sh_t = tens; sh_o = ones; end
        tick = (ncyc % SD) == SD - 1;
        prev = (ncyc / SD) % 4;
        if (!alarm) frames = 0;
        else if (tick && prev == 3) frames++;
        if (tick) begin
            slot   = ((ncyc + 1) / SD) % 4;
            on     = !alarm || ((frames / FF) % 2 == 0);
            d      = (slot == 0) ? oo : (slot == 1) ? ot : oh;
            blank  = (slot == 3) || !on
                  || (blank_lz && slot == 2 && oh == 4'd0)
                  || (blank_lz && slot == 1 && oh == 4'd0 && ot == 4'd0);
            onehot = 4'b0001 << slot;
            exp_an  = blank ? 4'hF : ~onehot;
            exp_seg = blank ? 7'h7F : ref_seg(d);
        end
        ncyc++;
        #1 check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        hundreds = h; tens = t; ones = o;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        ncyc = 0; frames = 0;
        sh_h = 4'd0; sh_t = 4'd0; sh_o = 4'd0;
        exp_an = 4'hF; exp_seg = 7'h7F;
        #1 check();
        @(posedge clk);
        #1 check();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #12 check();
        rst_n = 1'b1;

        tag = "pre_first_tick";
        run(2);

        tag = "load_123";
        do_load(4'd1, 4'd2, 4'd3);
        run(40);

        tag = "lz_007";
        blank_lz = 1'b1;
        do_load(4'd0, 4'd0, 4'd7);
        run(32);
        tag = "nolz_007";
        blank_lz = 1'b0;
        run(32);

        tag = "lz_000";
        blank_lz = 1'b1;
        do_load(4'd0, 4'd0, 4'd0);
        run(20);
        tag = "lz_045";
        do_load(4'd0, 4'd4, 4'd5);
        run(20);

        tag = "alarm_on";
        blank_lz = 1'b0;
        alarm = 1'b1;
        run(140);
        tag = "alarm_off";
        alarm = 1'b0;
        run(20);

        tag = "dash_A12";
        do_load(4'hA, 4'd1, 4'd2);
        run(20);

        tag = "load_on_tick";
        for (int i = 0; i < SD && (ncyc % SD) != SD - 1; i++) step();
        do_load(4'd9, 4'd8, 4'd6);
        run(20);

        tag = "load_held";
        hundreds = 4'd3; tens = 4'd3; ones = 4'd3;
        load = 1'b1;
        step();
        hundreds = 4'd5; tens = 4'd0; ones = 4'd1;
        step();
        load = 1'b0;
        run(20);

        tag = "random";
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                hundreds = 4'($urandom_range(0, 15));
                tens     = 4'($urandom_range(0, 15));
                ones     = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) begin
                    hundreds = 4'd0;
                    if ($urandom_range(0, 1) == 0) tens = 4'd0;
                end
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 59) == 0) alarm = ~alarm;
            step();
        end
        load = 1'b0;

        tag = "reset_mid_dig2";
        alarm = 1'b0;
        do_load(4'd7, 4'd7, 4'd7);
        for (int i = 0; i < 4 * SD && !(((ncyc / SD) % 4) == 2 && (ncyc % SD) == 1); i++) step();
        async_reset();
        tag = "after_reset";
        run(40);

        tag = "reset_in_alarm";
        alarm = 1'b1;
        run(50);
        async_reset();
        tag = "alarm_after_reset";
        run(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
